axi4_merge_wr: RTL and testbench

Write-channel counterpart of the read-side burst merger. It collects address-contiguous AXI4 write bursts from the slave side and issues one longer burst per group on the master side. W beats pass through, with a single re-generated `m_wlast` per merged burst. The one master B response per merged burst is fanned back out as one B response per original sub-burst, carrying the original IDs.

---
 rtl/axi4_merge_pkg.sv | 18 +
 rtl/axi4_merge_wr_bsplit.sv | 53 +++++
 rtl/common_fifo.sv | 57 +++++
 rtl/axi4_merge_wr.sv | 205 ++++++++++++++++++++
 tb/tb_axi4_merge_wr.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_merge_pkg.sv
// Shared types and constants for the AXI4 write-burst merger.
//   state_e   : merge FSM states (IDLE, COLLECT, FLUSH)
//   RESP_*    : AXI response encodings
//   MIN_MAX   : smallest legal value of the MAX parameter
package axi4_merge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int MIN_MAX = 2;

endpackage

// File: rtl/axi4_merge_wr_bsplit.sv
// Fans one master B response out into one slave B response per sub-burst.
//   sub_push_i/sub_id_i/sub_full_o : per-sub-burst ID queue (filled on s_AW)
//   grp_push_i/grp_cnt_i/grp_full_o: sub-bursts per merged burst (filled on flush)
//   s_bvalid_o/s_bready_i/s_bid_o/s_bresp_o : slave B channel
//   m_bvalid_i/m_bready_o/m_bresp_i         : master B channel
module axi4_merge_wr_bsplit #(
    parameter int IDSIZE = 4,
    parameter int MAX    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sub_push_i,
    input  logic [IDSIZE-1:0]        sub_id_i,
    output logic                     sub_full_o,
    input  logic                     grp_push_i,
    input  logic [$clog2(MAX+1)-1:0] grp_cnt_i,
    output logic                     grp_full_o,
    output logic                     s_bvalid_o,
    input  logic                     s_bready_i,
    output logic [IDSIZE-1:0]        s_bid_o,
    output logic [1:0]               s_bresp_o,
    input  logic                     m_bvalid_i,
    output logic                     m_bready_o,
    input  logic [1:0]               m_bresp_i
);
    localparam int CW = $clog2(MAX + 1);

    logic          sub_empty, grp_empty, sb_hs, grp_last;
    logic [CW-1:0] grp_head, bsub_cnt_q;

    common_fifo #(.WIDTH(IDSIZE), .DEPTH(2 * MAX)) u_sub_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(sub_push_i), .din_i(sub_id_i),
        .pop_i(sb_hs), .dout_o(s_bid_o), .full_o(sub_full_o), .empty_o(sub_empty)
    );

    common_fifo #(.WIDTH(CW), .DEPTH(4)) u_bgrp_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(grp_push_i), .din_i(grp_cnt_i),
        .pop_i(m_bready_o), .dout_o(grp_head), .full_o(grp_full_o), .empty_o(grp_empty)
    );

    assign s_bvalid_o = m_bvalid_i && !sub_empty;
    assign s_bresp_o  = m_bresp_i;
    assign sb_hs      = s_bvalid_o && s_bready_i;
    // The master response is held until the last sub-response of its group goes out.
    assign grp_last   = !grp_empty && (bsub_cnt_q == grp_head - CW'(1));
    assign m_bready_o = sb_hs && grp_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     bsub_cnt_q <= '0;
        else if (sb_hs) bsub_cnt_q <= grp_last ? '0 : bsub_cnt_q + CW'(1);
    end

endmodule

// File: rtl/common_fifo.sv
// Synchronous show-ahead FIFO used by the burst mergers.
//   clk, rst_n      : clock, async active-low reset
//   push_i, din_i   : write strobe and data (ignored when full)
//   pop_i           : read strobe (ignored when empty)
//   dout_o          : head entry, valid whenever empty_o is low
//   full_o, empty_o : occupancy flags
module common_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/axi4_merge_wr.sv
// AXI4 write-burst merger: joins address-contiguous slave AW bursts into one
// master burst, passes W through with a regenerated m_wlast, and splits the
// master B response back into one response per original sub-burst.
//   axi_aclk, axi_aresetn       : clock, async active-low reset
//   s_aw*, s_w*, s_b*           : slave-side AW / W / B channels
//   m_aw*, m_w*, m_b*           : master-side AW / W / B channels (m_awid = 0)
//   err_wlast                   : sticky flag, s_wlast disagreed with sub-burst length
// Build option: define AXI4_MERGE_WR_WLAST_CHECK_EN to enable the s_wlast checker.
module axi4_merge_wr
    import axi4_merge_pkg::*;
#(
    parameter int ASIZE   = 32,
    parameter int LSIZE   = 8,
    parameter int IDSIZE  = 4,
    parameter int DSIZE   = 32,
    parameter int MAX     = 8,
    parameter int TIMEOUT = 63
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ASIZE-1:0]  s_awaddr,
    input  logic [LSIZE-1:0]  s_awlen,
    input  logic [IDSIZE-1:0] s_awid,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [DSIZE-1:0]  s_wdata,
    input  logic              s_wlast,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [IDSIZE-1:0] s_bid,
    output logic [1:0]        s_bresp,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ASIZE-1:0]  m_awaddr,
    output logic [LSIZE-1:0]  m_awlen,
    output logic [IDSIZE-1:0] m_awid,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [DSIZE-1:0]  m_wdata,
    output logic              m_wlast,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bresp,
    output logic              err_wlast
);
    localparam int CW = $clog2(MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 2);

    if (MAX < MIN_MAX) begin : g_max_check
        $error("axi4_merge_wr: MAX must be at least %0d", MIN_MAX);
    end

    state_e           state_q, state_d;
    logic [ASIZE-1:0] base_addr_q, base_addr_d, end_addr_q, end_addr_d;
    logic [LSIZE-1:0] tot_len_q, tot_len_d, beat_cnt_q, wlen_head;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [LSIZE:0]   len_sum;
    logic [ASIZE+LSIZE-1:0] aw_head;
    logic can_join, aw_rdy, aw_hs, w_hs, flush_push;
    logic sub_full, aw_full, aw_empty, wlen_full, wlen_empty, grp_full;

    // Merged length must still fit in LSIZE bits: carry-out of the sum means overflow.
    assign len_sum  = {1'b0, tot_len_q} + {1'b0, s_awlen} + (LSIZE + 1)'(1);
    assign can_join = s_awvalid && (s_awaddr == end_addr_q + ASIZE'(1))
                      && (cnt_q < CW'(MAX)) && !len_sum[LSIZE];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        base_addr_d = base_addr_q;
        end_addr_d  = end_addr_q;
        tot_len_d   = tot_len_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        aw_rdy      = 1'b0;
        flush_push  = 1'b0;
        case (state_q)
            IDLE: begin
                aw_rdy = !sub_full;
                if (s_awvalid && aw_rdy) begin
                    base_addr_d = s_awaddr;
                    tot_len_d   = s_awlen;
                    end_addr_d  = s_awaddr + ASIZE'(s_awlen);
                    cnt_d       = CW'(1);
                    timer_d     = '0;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                aw_rdy = can_join && !sub_full;
                if (s_awvalid && aw_rdy) begin
                    tot_len_d  = len_sum[LSIZE-1:0];
                    end_addr_d = s_awaddr + ASIZE'(s_awlen);
                    cnt_d      = cnt_q + CW'(1);
                    timer_d    = '0;
                end else if ((s_awvalid && !can_join) || (cnt_q == CW'(MAX))
                             || (timer_q == TW'(TIMEOUT))) begin
                    state_d = FLUSH;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            FLUSH: begin
                if (!aw_full && !wlen_full && !grp_full) begin
                    flush_push = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= IDLE;
            base_addr_q <= '0;
            end_addr_q  <= '0;
            tot_len_q   <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_addr_q <= base_addr_d;
            end_addr_q  <= end_addr_d;
            tot_len_q   <= tot_len_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
        end
    end

    // Gated by reset so the slave never sees AW ready while reset is asserted.
    assign s_awready = axi_aresetn && aw_rdy;
    assign aw_hs     = s_awvalid && s_awready;

    common_fifo #(.WIDTH(ASIZE + LSIZE), .DEPTH(4)) u_aw_fifo (
        .clk(axi_aclk), .rst_n(axi_aresetn), .push_i(flush_push),
        .din_i({base_addr_q, tot_len_q}), .pop_i(m_awvalid && m_awready),
        .dout_o(aw_head), .full_o(aw_full), .empty_o(aw_empty)
    );

    assign m_awvalid = !aw_empty;
    assign m_awaddr  = aw_head[ASIZE+LSIZE-1:LSIZE];
    assign m_awlen   = aw_head[LSIZE-1:0];
    assign m_awid    = '0;

    common_fifo #(.WIDTH(LSIZE), .DEPTH(4)) u_wlen_fifo (
        .clk(axi_aclk), .rst_n(axi_aresetn), .push_i(flush_push),
        .din_i(tot_len_q), .pop_i(w_hs && m_wlast),
        .dout_o(wlen_head), .full_o(wlen_full), .empty_o(wlen_empty)
    );

    // W is held back until its merged burst has been flushed into wlen_fifo.
    assign m_wvalid = s_wvalid && !wlen_empty;
    assign s_wready = m_wready && !wlen_empty;
    assign m_wdata  = s_wdata;
    assign m_wlast  = !wlen_empty && (beat_cnt_q == wlen_head);
    assign w_hs     = m_wvalid && m_wready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) beat_cnt_q <= '0;
        else if (w_hs)    beat_cnt_q <= m_wlast ? '0 : beat_cnt_q + LSIZE'(1);
    end

    axi4_merge_wr_bsplit #(.IDSIZE(IDSIZE), .MAX(MAX)) u_bsplit (
        .clk(axi_aclk), .rst_n(axi_aresetn),
        .sub_push_i(aw_hs), .sub_id_i(s_awid), .sub_full_o(sub_full),
        .grp_push_i(flush_push), .grp_cnt_i(cnt_q), .grp_full_o(grp_full),
        .s_bvalid_o(s_bvalid), .s_bready_i(s_bready), .s_bid_o(s_bid), .s_bresp_o(s_bresp),
        .m_bvalid_i(m_bvalid), .m_bready_o(m_bready), .m_bresp_i(m_bresp)
    );

`ifdef AXI4_MERGE_WR_WLAST_CHECK_EN
    // chk_fifo never outgrows sub_fifo (W drains before B), so it needs no backpressure.
    logic [LSIZE-1:0] chk_head, chk_beat_q;
    logic             chk_empty, unused_chk_full, sub_end, err_q;

    common_fifo #(.WIDTH(LSIZE), .DEPTH(2 * MAX)) u_chk_fifo (
        .clk(axi_aclk), .rst_n(axi_aresetn), .push_i(aw_hs), .din_i(s_awlen),
        .pop_i(w_hs && sub_end), .dout_o(chk_head), .full_o(unused_chk_full),
        .empty_o(chk_empty)
    );

    assign sub_end = !chk_empty && (chk_beat_q == chk_head);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            chk_beat_q <= '0;
            err_q      <= 1'b0;
        end else if (w_hs) begin
            chk_beat_q <= sub_end ? '0 : chk_beat_q + LSIZE'(1);
            if (s_wlast != sub_end) err_q <= 1'b1;
        end
    end

    assign err_wlast = err_q;
`else
    logic unused_wlast;
    assign unused_wlast = s_wlast;
    assign err_wlast    = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_merge_wr.sv
// Directed self-checking bench for axi4_merge_wr (default parameters).
module tb_axi4_merge_wr;
    import axi4_merge_pkg::*;

`ifdef AXI4_MERGE_WR_WLAST_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic        s_bvalid, s_bready, m_awvalid, m_awready, m_wvalid, m_wready;
    logic        m_wlast, m_bvalid, m_bready, err_wlast;
    logic [31:0] s_awaddr, s_wdata, m_awaddr, m_wdata;
    logic [7:0]  s_awlen, m_awlen;
    logic [3:0]  s_awid, s_bid, m_awid;
    logic [1:0]  s_bresp, m_bresp;

    always #5 axi_aclk = ~axi_aclk;

    axi4_merge_wr dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awid(s_awid),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awid(m_awid),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .err_wlast(err_wlast)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;

    aw_t         maw_q[$];
    b_t          sb_q[$];
    int          wlast_q[$];
    int          mw_cnt = 0;
    logic [31:0] last_wdata = '0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] wseq = 32'hA000_0000;

    // s_bready is either held high or toggled every cycle.
    logic b_toggle = 1'b0;
    logic tog = 1'b0;
    always begin
        @(posedge axi_aclk);
        #1 tog = ~tog;
    end
    assign s_bready = b_toggle ? tog : 1'b1;

    // Monitor: records handshakes on the falling edge, away from the active edge.
    always @(negedge axi_aclk) begin
        if (m_awvalid && m_awready) maw_q.push_back('{m_awaddr, m_awlen});
        if (m_wvalid && m_wready) begin
            mw_cnt++;
            last_wdata = m_wdata;
            if (m_wlast) wlast_q.push_back(mw_cnt);
        end
        if (s_bvalid && s_bready) sb_q.push_back('{s_bid, s_bresp});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge axi_aclk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        int   n = 0;
        logic rdy;
        s_awvalid = 1'b1; s_awaddr = a; s_awlen = l; s_awid = id;
        do begin
            #1 rdy = s_awready;
            @(posedge axi_aclk); #1;
            n++;
        end while (!rdy && n < 400);
        check("aw_handshake", 64'(rdy), 64'd1);
        s_awvalid = 1'b0;
    endtask

    task automatic send_beat(input logic last);
        int   n = 0;
        logic rdy;
        s_wvalid = 1'b1; s_wdata = wseq; s_wlast = last;
        do begin
            #1 rdy = s_wready;
            @(posedge axi_aclk); #1;
            n++;
        end while (!rdy && n < 400);
        check("w_handshake", 64'(rdy), 64'd1);
        s_wvalid = 1'b0; s_wlast = 1'b0;
        wseq++;
    endtask

    task automatic send_sub(input int len);
        for (int i = 0; i <= len; i++) send_beat(i == len);
    endtask

    task automatic send_b(input logic [1:0] r);
        int   n = 0;
        logic rdy;
        m_bvalid = 1'b1; m_bresp = r;
        do begin
            #1 rdy = m_bready;
            @(posedge axi_aclk); #1;
            n++;
        end while (!rdy && n < 100);
        check("b_handshake", 64'(rdy), 64'd1);
        m_bvalid = 1'b0;
    endtask

    task automatic check_aw(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
        check({tag, "_addr"}, 64'(maw_q[idx].addr), 64'(a));
        check({tag, "_len"}, 64'(maw_q[idx].len), 64'(l));
    endtask

    task automatic check_b(input string tag, input int idx, input logic [3:0] id, input logic [1:0] r);
        check({tag, "_id"}, 64'(sb_q[idx].id), 64'(id));
        check({tag, "_resp"}, 64'(sb_q[idx].resp), 64'(r));
    endtask

    initial begin
        // Reset with every input asserted that could leak through.
        s_awvalid = 1'b1; s_awaddr = '0; s_awlen = '0; s_awid = '0;
        s_wvalid = 1'b1; s_wdata = '0; s_wlast = 1'b0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = RESP_OKAY;
        axi_aresetn = 1'b0;
        tick(2);
        check("rst_s_awready", 64'(s_awready), 64'd0);
        check("rst_s_wready",  64'(s_wready),  64'd0);
        check("rst_s_bvalid",  64'(s_bvalid),  64'd0);
        check("rst_m_awvalid", 64'(m_awvalid), 64'd0);
        check("rst_m_wvalid",  64'(m_wvalid),  64'd0);
        check("rst_m_wlast",   64'(m_wlast),   64'd0);
        check("rst_m_bready",  64'(m_bready),  64'd0);
        check("rst_err_wlast", 64'(err_wlast), 64'd0);
        s_awvalid = 1'b0; s_wvalid = 1'b0; m_bvalid = 1'b0;
        axi_aresetn = 1'b1;
        tick(1);

        // 1: three contiguous bursts merge into one 16-beat burst.
        send_aw(32'h00, 8'd3, 4'd1);
        send_aw(32'h04, 8'd3, 4'd2);
        send_aw(32'h08, 8'd7, 4'd3);
        tick(80);
        check("t1_aw_count", 64'(maw_q.size()), 64'd1);
        check_aw("t1_aw", 0, 32'h00, 8'd15);
        send_sub(3); send_sub(3); send_sub(7);
        tick(2);
        check("t1_wlast_count", 64'(wlast_q.size()), 64'd1);
        check("t1_wlast_pos", 64'(wlast_q[0]), 64'd16);
        check("t1_wdata", 64'(last_wdata), 64'(32'hA000_000F));
        send_b(RESP_OKAY);
        tick(2);
        check("t1_b_count", 64'(sb_q.size()), 64'd3);
        check_b("t1_b0", 0, 4'd1, RESP_OKAY);
        check_b("t1_b1", 1, 4'd2, RESP_OKAY);
        check_b("t1_b2", 2, 4'd3, RESP_OKAY);

        // 2: non-contiguous bursts stay separate.
        send_aw(32'h00, 8'd1, 4'd4);
        send_aw(32'h10, 8'd1, 4'd5);
        tick(80);
        check("t2_aw_count", 64'(maw_q.size()), 64'd3);
        check_aw("t2_aw0", 1, 32'h00, 8'd1);
        check_aw("t2_aw1", 2, 32'h10, 8'd1);
        send_sub(1); send_sub(1);
        tick(2);
        check("t2_wlast0", 64'(wlast_q[1]), 64'd18);
        check("t2_wlast1", 64'(wlast_q[2]), 64'd20);
        send_b(RESP_OKAY); send_b(RESP_OKAY);
        tick(2);
        check("t2_b_count", 64'(sb_q.size()), 64'd5);
        check_b("t2_b0", 3, 4'd4, RESP_OKAY);
        check_b("t2_b1", 4, 4'd5, RESP_OKAY);

        // 3: ten single-beat bursts hit the MAX=8 cap.
        for (int i = 0; i < 10; i++) send_aw(32'h100 + 32'(i), 8'd0, 4'(i));
        tick(80);
        check("t3_aw_count", 64'(maw_q.size()), 64'd5);
        check_aw("t3_aw0", 3, 32'h100, 8'd7);
        check_aw("t3_aw1", 4, 32'h108, 8'd1);
        for (int i = 0; i < 10; i++) send_sub(0);
        tick(2);
        check("t3_wlast0", 64'(wlast_q[3]), 64'd28);
        check("t3_wlast1", 64'(wlast_q[4]), 64'd30);
        send_b(RESP_OKAY);
        tick(2);
        check("t3_bgrp0", 64'(sb_q.size()), 64'd13);
        send_b(RESP_OKAY);
        tick(2);
        check("t3_bgrp1", 64'(sb_q.size()), 64'd15);
        check_b("t3_b_last", 14, 4'd9, RESP_OKAY);

        // 4: merged length would exceed 255, so no join.
        send_aw(32'h1000, 8'd200, 4'd1);
        send_aw(32'h10C9, 8'd100, 4'd2);
        tick(80);
        check("t4_aw_count", 64'(maw_q.size()), 64'd7);
        check_aw("t4_aw0", 5, 32'h1000, 8'd200);
        check_aw("t4_aw1", 6, 32'h10C9, 8'd100);
        send_sub(200); send_sub(100);
        tick(2);
        check("t4_wlast0", 64'(wlast_q[5]), 64'd231);
        check("t4_wlast1", 64'(wlast_q[6]), 64'd332);
        send_b(RESP_OKAY); send_b(RESP_OKAY);
        tick(2);
        check("t4_b_count", 64'(sb_q.size()), 64'd17);

        // 5: AW backpressure, toggling s_bready, SLVERR fan-out.
        m_awready = 1'b0;
        b_toggle  = 1'b1;
        send_aw(32'h2000, 8'd3, 4'd7);
        send_aw(32'h2004, 8'd1, 4'd8);
        send_aw(32'h3000, 8'd0, 4'd9);
        tick(80);
        send_sub(3); send_sub(1); send_sub(0);
        tick(20);
        check("t5_aw_held", 64'(maw_q.size()), 64'd7);
        check("t5_awvalid", 64'(m_awvalid), 64'd1);
        check("t5_wlast0", 64'(wlast_q[7]), 64'd338);
        check("t5_wlast1", 64'(wlast_q[8]), 64'd339);
        check("t5_wdata", 64'(last_wdata), 64'(wseq - 32'd1));
        m_awready = 1'b1;
        tick(3);
        check("t5_aw_count", 64'(maw_q.size()), 64'd9);
        check_aw("t5_aw0", 7, 32'h2000, 8'd5);
        check_aw("t5_aw1", 8, 32'h3000, 8'd0);
        send_b(RESP_SLVERR); send_b(RESP_SLVERR);
        tick(4);
        b_toggle = 1'b0;
        check("t5_b_count", 64'(sb_q.size()), 64'd20);
        check_b("t5_b0", 17, 4'd7, RESP_SLVERR);
        check_b("t5_b1", 18, 4'd8, RESP_SLVERR);
        check_b("t5_b2", 19, 4'd9, RESP_SLVERR);

        // 6: s_wlast on beat 2 of a 4-beat sub-burst.
        send_aw(32'h4000, 8'd3, 4'd3);
        tick(80);
        send_beat(1'b0);
        check("t6_err_before", 64'(err_wlast), 64'd0);
        send_beat(1'b1);
        check("t6_err_set", 64'(err_wlast), 64'(EXP_ERR));
        send_beat(1'b0);
        send_beat(1'b0);
        send_b(RESP_OKAY);
        tick(5);
        check("t6_err_sticky", 64'(err_wlast), 64'(EXP_ERR));
        check("t6_wlast", 64'(wlast_q[9]), 64'd343);
        check_b("t6_b", 20, 4'd3, RESP_OKAY);

        // 7: reset in COLLECT discards the partial group.
        send_aw(32'h5000, 8'd1, 4'd6);
        tick(3);
        s_awvalid = 1'b1;
        axi_aresetn = 1'b0;
        #1;
        check("t7_rst_awready", 64'(s_awready), 64'd0);
        check("t7_rst_err", 64'(err_wlast), 64'd0);
        tick(2);
        s_awvalid = 1'b0;
        axi_aresetn = 1'b1;
        tick(80);
        check("t7_discarded", 64'(maw_q.size()), 64'd10);
        send_aw(32'h6000, 8'd0, 4'd2);
        tick(80);
        check_aw("t7_aw", 10, 32'h6000, 8'd0);
        send_sub(0);
        send_b(RESP_OKAY);
        tick(2);
        check("t7_wlast", 64'(wlast_q[10]), 64'd344);
        check_b("t7_b", 21, 4'd2, RESP_OKAY);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
